// File: rtl/noc_local_injector.sv
// Round-robin packet injector for the router LOCAL port.
// Sends header, size and payload flits under credit flow control.
module noc_local_injector #(
   parameter int TAM_FLIT = 16,
   parameter int NREQ = 4,
   parameter logic [TAM_FLIT-1:0] address = '0
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [NREQ-1:0]          i_req,
   input  logic [NREQ*TAM_FLIT-1:0] i_target,
   input  logic [NREQ*TAM_FLIT-1:0] i_size,
   input  logic [NREQ*TAM_FLIT-1:0] i_pay_data,
   input  logic [NREQ-1:0]          i_pay_valid,
   output logic [NREQ-1:0]          o_pay_ack,
   output logic [NREQ-1:0]          o_grant,
   output logic                     o_tx,
   output logic [TAM_FLIT-1:0]      o_data,
   input  logic                     i_credit,
   output logic                     o_clk_tx,
   output logic                     o_busy,
   output logic                     o_pkt_done,
   output logic                     o_self_hit
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, HEADER, SIZE, PAYLOAD} state_t;

   state_t state, state_nx;
   logic [IW-1:0] ptr, win, pick;
   logic any_req;
   logic [NREQ-1:0] grant;
   logic [TAM_FLIT-1:0] target, size, remain;
   logic [TAM_FLIT-1:0] pick_target, pick_size;
   logic [TAM_FLIT-1:0] pay_data;
   logic pay_valid, done, self_hit;
   logic xfer, last;

   // Walk down so the lowest offset from ptr+1 wins.
   always_comb begin
      int idx;
      idx = 0;
      any_req = 1'b0;
      pick = '0;
      for (int i = NREQ; i >= 1; i--) begin
         idx = (int'(ptr) + i) % NREQ;
         if (i_req[idx]) begin
            any_req = 1'b1;
            pick = IW'(idx);
         end
      end
   end

   assign pick_target = i_target[int'(pick)*TAM_FLIT +: TAM_FLIT];
   assign pick_size = i_size[int'(pick)*TAM_FLIT +: TAM_FLIT];
   assign pay_data = i_pay_data[int'(win)*TAM_FLIT +: TAM_FLIT];
   assign pay_valid = i_pay_valid[win];

   assign xfer = o_tx & i_credit;
   assign last = (state == PAYLOAD) && (remain == TAM_FLIT'(1));

   always_ff @(posedge i_clk) begin
      if (!i_rst) state <= IDLE;
      else state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (any_req) state_nx = HEADER;
         HEADER:  if (xfer) state_nx = SIZE;
         SIZE: begin
            if (xfer) state_nx = (size == '0) ? IDLE : PAYLOAD;
         end
         PAYLOAD: if (xfer && last) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      o_tx = 1'b0;
      o_data = '0;
      o_pay_ack = '0;
      unique case (state)
         IDLE: ;
         HEADER: begin
            o_tx = 1'b1;
            o_data = target;
         end
         SIZE: begin
            o_tx = 1'b1;
            o_data = size;
         end
         PAYLOAD: begin
            o_tx = pay_valid;
            o_data = pay_data;
            o_pay_ack[win] = pay_valid & i_credit;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         ptr <= IW'(NREQ - 1);
         win <= '0;
         grant <= '0;
         target <= '0;
         size <= '0;
         remain <= '0;
         done <= 1'b0;
         self_hit <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (any_req) begin
                  win <= pick;
                  grant <= NREQ'(1) << pick;
                  target <= pick_target;
                  size <= pick_size;
                  self_hit <= (pick_target == address);
               end
            end
            SIZE: begin
               if (xfer) begin
                  remain <= size;
                  if (size == '0) begin
                     grant <= '0;
                     done <= 1'b1;
                  end
               end
            end
            PAYLOAD: begin
               if (xfer) begin
                  remain <= remain - TAM_FLIT'(1);
                  if (last) begin
                     grant <= '0;
                     ptr <= win;
                     done <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign o_grant = grant;
   assign o_busy = (state != IDLE);
   assign o_pkt_done = done;
   assign o_self_hit = self_hit;
   assign o_clk_tx = i_clk;

endmodule

// File: tb/tb_noc_local_injector.sv
// Bench for noc_local_injector: scripted scenarios plus randomized
// traffic checked against a transaction-level round-robin model.
module tb_noc_local_injector;
   localparam int N = 4;
   localparam int W = 16;
   localparam logic [W-1:0] ADDR = 16'h0011;

   logic clk = 1'b0;
   logic rst;
   logic [N-1:0] req, pv, ack, grant;
   logic [N*W-1:0] tgt_bus, sz_bus, pd_bus;
   logic tx, cred, clk_tx, busy, done, self_hit;
   logic [W-1:0] data;

   always #5 clk = ~clk;

   noc_local_injector #(.TAM_FLIT(W), .NREQ(N), .address(ADDR)) dut (
      .i_clk(clk), .i_rst(rst), .i_req(req),
      .i_target(tgt_bus), .i_size(sz_bus),
      .i_pay_data(pd_bus), .i_pay_valid(pv),
      .o_pay_ack(ack), .o_grant(grant), .o_tx(tx),
      .o_data(data), .i_credit(cred), .o_clk_tx(clk_tx),
      .o_busy(busy), .o_pkt_done(done), .o_self_hit(self_hit)
   );

   int vec = 0;
   int err = 0;
   int np[N], cp[N], fl[N];
   logic [W-1:0] ptg[N][4], psz[N][4], pw[N][4][16];
   bit auto_mode;
   int cred_pct, val_pct;
   int mptr;

   logic lg_tx[$], lg_cr[$], lg_busy[$], lg_done[$], lg_self[$];
   logic [W-1:0] lg_d[$];
   logic [N-1:0] lg_g[$], lg_ack[$];
   logic [W-1:0] xd[$], ed[$];
   logic [N-1:0] xg[$], eg[$];
   int xc[$];

   // Each source presents its current packet until the last flit leaves
   always_comb begin
      for (int k = 0; k < N; k++) begin
         req[k] = (cp[k] < np[k]);
         tgt_bus[k*W +: W] = ptg[k][cp[k] & 3];
         sz_bus[k*W +: W] = psz[k][cp[k] & 3];
         pd_bus[k*W +: W] = pw[k][cp[k] & 3][(fl[k] + 14) & 15];
      end
   end

   task automatic clear_src();
      for (int k = 0; k < N; k++) begin
         np[k] = 0;
         cp[k] = 0;
         fl[k] = 0;
      end
   endtask

   task automatic new_pkt(input int k, input int p, input int sz);
      ptg[k][p] = W'($urandom);
      psz[k][p] = W'(sz);
      for (int j = 0; j < 16; j++) pw[k][p][j] = W'($urandom);
   endtask

   task automatic clear_logs();
      lg_tx.delete(); lg_cr.delete(); lg_busy.delete();
      lg_done.delete(); lg_self.delete(); lg_d.delete();
      lg_g.delete(); lg_ack.delete();
   endtask

   task automatic drive_cycle();
      logic x, r;
      logic [N-1:0] g;
      if (auto_mode) begin
         cred = ($urandom_range(0, 99) < cred_pct);
         for (int k = 0; k < N; k++)
            pv[k] = ($urandom_range(0, 99) < val_pct);
      end
      #1;
      lg_tx.push_back(tx); lg_cr.push_back(cred);
      lg_busy.push_back(busy); lg_done.push_back(done);
      lg_self.push_back(self_hit); lg_d.push_back(data);
      lg_g.push_back(grant); lg_ack.push_back(ack);
      x = tx & cred;
      g = grant;
      r = rst;
      @(posedge clk);
      if (!r) begin
         for (int k = 0; k < N; k++) fl[k] = 0;
      end else if (x) begin
         for (int k = 0; k < N; k++) if (g[k]) begin
            fl[k]++;
            if (fl[k] == int'(psz[k][cp[k] & 3]) + 2) begin
               cp[k]++;
               fl[k] = 0;
            end
         end
      end
      @(negedge clk);
   endtask

   function automatic bit all_done();
      for (int k = 0; k < N; k++) if (cp[k] < np[k]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic run_to_end(input int bound, output bit ok);
      int n = 0;
      while (!all_done() && n < bound) begin
         drive_cycle();
         n++;
      end
      ok = all_done();
      drive_cycle();
      drive_cycle();
   endtask

   task automatic collect();
      xd.delete(); xg.delete(); xc.delete();
      for (int i = 0; i < lg_tx.size(); i++)
         if (lg_tx[i] && lg_cr[i]) begin
            xd.push_back(lg_d[i]);
            xg.push_back(lg_g[i]);
            xc.push_back(i);
         end
   endtask

   // Round robin over sources with packets left; zero-size packets leave ptr alone
   task automatic build_model();
      int c[N];
      int w, j;
      ed.delete(); eg.delete();
      for (int k = 0; k < N; k++) c[k] = 0;
      forever begin
         w = -1;
         for (int i = 1; i <= N; i++) begin
            j = (mptr + i) % N;
            if (w < 0 && c[j] < np[j]) w = j;
         end
         if (w < 0) break;
         ed.push_back(ptg[w][c[w]]);
         ed.push_back(psz[w][c[w]]);
         for (int p = 0; p < int'(psz[w][c[w]]); p++)
            ed.push_back(pw[w][c[w]][p % 16]);
         for (int p = 0; p < int'(psz[w][c[w]]) + 2; p++)
            eg.push_back(N'(1) << w);
         if (psz[w][c[w]] != '0) mptr = w;
         c[w]++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; auto_mode = 0; cred = 1'b1; pv = '1;
      clear_src(); np[0] = 1; new_pkt(0, 0, 1);
      clear_logs();
      repeat (3) drive_cycle();
      vec++;
      if ({lg_g[2], lg_tx[2], lg_d[2], lg_busy[2], lg_done[2], lg_self[2],
           lg_ack[2]} !== '0) begin
         err++;
         $display("FAIL reset_outputs: grant=%b tx=%b data=%h busy=%b done=%b self=%b ack=%b required all 0",
                  lg_g[2], lg_tx[2], lg_d[2], lg_busy[2], lg_done[2], lg_self[2], lg_ack[2]);
      end
      @(posedge clk); #1;
      vec++;
      if (clk_tx !== 1'b1) begin
         err++;
         $display("FAIL clk_tx_high: got %b required 1", clk_tx);
      end
      @(negedge clk);
      vec++;
      if (clk_tx !== 1'b0) begin
         err++;
         $display("FAIL clk_tx_low: got %b required 0", clk_tx);
      end
      rst = 1'b1;
      mptr = N - 1;
   endtask

   task automatic test_single();
      bit ok;
      int nd;
      clear_src(); np[0] = 1; new_pkt(0, 0, 2);
      ptg[0][0] = 16'h0011;
      auto_mode = 0; cred = 1'b1; pv = '1;
      build_model(); clear_logs();
      run_to_end(20, ok); collect();
      vec++;
      if (!ok || xd.size() != 4) begin
         err++;
         $display("FAIL single_count: got %0d flits required 4", xd.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            vec++;
            if (xd[i] !== ed[i] || xg[i] !== 4'b0001 || xc[i] != i + 1) begin
               err++;
               $display("FAIL single_flit%0d: got %h/%b@%0d required %h/0001@%0d",
                        i, xd[i], xg[i], xc[i], ed[i], i + 1);
            end
         end
         vec++;
         if (lg_ack[1] !== 4'b0000 || lg_ack[3] !== 4'b0001) begin
            err++;
            $display("FAIL single_ack: got %b,%b required 0000,0001", lg_ack[1], lg_ack[3]);
         end
      end
      nd = 0;
      foreach (lg_done[i]) if (lg_done[i]) nd++;
      vec++;
      if (nd != 1 || lg_done[5] !== 1'b1) begin
         err++;
         $display("FAIL single_done: got %0d pulses required 1 at cycle 5", nd);
      end
      vec++;
      if (lg_self[1] !== 1'b1 || lg_busy[lg_busy.size()-1] !== 1'b0) begin
         err++;
         $display("FAIL single_status: self=%b busy_end=%b required 1,0",
                  lg_self[1], lg_busy[lg_busy.size()-1]);
      end
   endtask

   task automatic test_round_robin();
      bit ok;
      clear_src();
      for (int k = 0; k < N; k++) begin
         np[k] = 2;
         new_pkt(k, 0, 1); new_pkt(k, 1, 1);
      end
      auto_mode = 0; cred = 1'b1; pv = '1;
      build_model(); clear_logs();
      run_to_end(100, ok); collect();
      vec++;
      if (!ok || xd.size() != ed.size()) begin
         err++;
         $display("FAIL rr_count: got %0d flits required %0d", xd.size(), ed.size());
      end else begin
         for (int i = 0; i < xd.size(); i++) begin
            vec++;
            if (xd[i] !== ed[i] || xg[i] !== eg[i]) begin
               err++;
               $display("FAIL rr_flit%0d: got %h/%b required %h/%b",
                        i, xd[i], xg[i], ed[i], eg[i]);
            end
         end
         for (int p = 1; p < 8; p++) begin
            vec++;
            if (xc[3*p] - xc[3*p-1] != 2 || lg_busy[xc[3*p]-1] !== 1'b0) begin
               err++;
               $display("FAIL rr_gap%0d: got gap %0d required 2 idle cycle", p,
                        xc[3*p] - xc[3*p-1]);
            end
         end
      end
   endtask

   task automatic test_header_stall();
      bit ok;
      clear_src(); np[3] = 1; new_pkt(3, 0, 1);
      auto_mode = 0; cred = 1'b1; pv = '1;
      build_model(); clear_logs();
      drive_cycle();
      cred = 1'b0;
      repeat (3) drive_cycle();
      for (int i = 1; i <= 3; i++) begin
         vec++;
         if (lg_tx[i] !== 1'b1 || lg_d[i] !== ptg[3][0] || lg_g[i] !== 4'b1000) begin
            err++;
            $display("FAIL stall_hold%0d: got tx=%b data=%h grant=%b required 1/%h/1000",
                     i, lg_tx[i], lg_d[i], lg_g[i], ptg[3][0]);
         end
      end
      cred = 1'b1;
      run_to_end(20, ok); collect();
      vec++;
      if (!ok || xd.size() != 3 || xc[0] != 4) begin
         err++;
         $display("FAIL stall_count: got %0d flits required 3 starting cycle 4", xd.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            vec++;
            if (xd[i] !== ed[i] || xg[i] !== eg[i]) begin
               err++;
               $display("FAIL stall_flit%0d: got %h required %h", i, xd[i], ed[i]);
            end
         end
      end
   endtask

   task automatic test_size_zero();
      bit ok;
      logic [N-1:0] acc;
      clear_src(); np[2] = 1; new_pkt(2, 0, 0);
      auto_mode = 0; cred = 1'b1; pv = '1;
      build_model(); clear_logs();
      run_to_end(20, ok); collect();
      vec++;
      if (!ok || xd.size() != 2) begin
         err++;
         $display("FAIL size0_count: got %0d flits required 2", xd.size());
      end else begin
         vec++;
         if (xd[0] !== ptg[2][0] || xd[1] !== 16'h0000 || xg[1] !== 4'b0100) begin
            err++;
            $display("FAIL size0_flits: got %h,%h required %h,0000", xd[0], xd[1], ptg[2][0]);
         end
      end
      acc = '0;
      foreach (lg_ack[i]) acc |= lg_ack[i];
      vec++;
      if (acc !== '0 || lg_busy[lg_busy.size()-1] !== 1'b0) begin
         err++;
         $display("FAIL size0_ack: got ack %b busy %b required 0000, 0", acc,
                  lg_busy[lg_busy.size()-1]);
      end
   endtask

   task automatic test_payload_gap();
      bit ok;
      int n, nd;
      clear_src(); np[1] = 1; new_pkt(1, 0, 3);
      auto_mode = 0; cred = 1'b1; pv = '1;
      build_model(); clear_logs();
      n = 0;
      while (fl[1] < 3 && n < 20) begin
         drive_cycle();
         n++;
      end
      pv = '0;
      repeat (2) drive_cycle();
      for (int i = n; i < n + 2; i++) begin
         vec++;
         if (lg_tx[i] !== 1'b0 || lg_ack[i] !== '0 || lg_d[i] !== pw[1][0][1]
             || fl[1] != 3) begin
            err++;
            $display("FAIL gap_idle%0d: got tx=%b ack=%b data=%h required 0/0000/%h",
                     i, lg_tx[i], lg_ack[i], lg_d[i], pw[1][0][1]);
         end
      end
      pv = '1;
      run_to_end(20, ok); collect();
      vec++;
      if (!ok || xd.size() != 5) begin
         err++;
         $display("FAIL gap_count: got %0d flits required 5", xd.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            vec++;
            if (xd[i] !== ed[i] || xg[i] !== eg[i]) begin
               err++;
               $display("FAIL gap_flit%0d: got %h required %h", i, xd[i], ed[i]);
            end
         end
      end
      nd = 0;
      foreach (lg_done[i]) if (lg_done[i]) nd++;
      vec++;
      if (nd != 1) begin
         err++;
         $display("FAIL gap_done: got %0d pulses required 1", nd);
      end
   endtask

   task automatic test_reset_midpacket();
      bit ok;
      int nd;
      clear_src(); np[2] = 1; new_pkt(2, 0, 0);
      psz[2][0] = 16'hFFFF;
      auto_mode = 0; cred = 1'b1; pv = '1;
      clear_logs();
      repeat (40) drive_cycle();
      collect();
      nd = 0;
      foreach (lg_done[i]) if (lg_done[i]) nd++;
      vec++;
      if (xd.size() != 39 || xd[1] !== 16'hFFFF || nd != 0 || busy !== 1'b1) begin
         err++;
         $display("FAIL big_size: got %0d flits size %h done %0d busy %b required 39/ffff/0/1",
                  xd.size(), xd[1], nd, busy);
      end
      rst = 1'b0;
      drive_cycle();
      rst = 1'b1;
      mptr = N - 1;
      clear_src();
      np[0] = 1; new_pkt(0, 0, 1);
      np[2] = 1; new_pkt(2, 0, 1);
      build_model(); clear_logs();
      run_to_end(30, ok); collect();
      vec++;
      if ({lg_g[0], lg_tx[0], lg_d[0], lg_busy[0], lg_done[0], lg_self[0],
           lg_ack[0]} !== '0) begin
         err++;
         $display("FAIL midreset_outputs: grant=%b tx=%b data=%h busy=%b done=%b required 0",
                  lg_g[0], lg_tx[0], lg_d[0], lg_busy[0], lg_done[0]);
      end
      vec++;
      if (!ok || xd.size() != 6) begin
         err++;
         $display("FAIL midreset_count: got %0d flits required 6", xd.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            vec++;
            if (xd[i] !== ed[i] || xg[i] !== eg[i]) begin
               err++;
               $display("FAIL midreset_flit%0d: got %h/%b required %h/%b",
                        i, xd[i], xg[i], ed[i], eg[i]);
            end
         end
      end
   endtask

   task automatic test_random(input int round);
      bit ok;
      int npk, npay, nd, na, bad;
      clear_src();
      npk = 0; npay = 0;
      for (int k = 0; k < N; k++) begin
         np[k] = $urandom_range(1, 3);
         for (int p = 0; p < np[k]; p++) begin
            new_pkt(k, p, $urandom_range(1, 6));
            npk++;
            npay += int'(psz[k][p]);
         end
      end
      auto_mode = 1; cred_pct = 70; val_pct = 75;
      build_model(); clear_logs();
      run_to_end(800, ok); collect();
      vec++;
      if (!ok || xd.size() != ed.size()) begin
         err++;
         $display("FAIL rand%0d_count: got %0d flits required %0d", round,
                  xd.size(), ed.size());
      end else begin
         bad = 0;
         for (int i = 0; i < xd.size(); i++)
            if (xd[i] !== ed[i] || xg[i] !== eg[i]) begin
               if (bad == 0)
                  $display("FAIL rand%0d_flit%0d: got %h/%b required %h/%b",
                           round, i, xd[i], xg[i], ed[i], eg[i]);
               bad++;
            end
         vec++;
         if (bad != 0) err++;
      end
      nd = 0; na = 0; bad = 0;
      for (int i = 0; i < lg_done.size(); i++) begin
         if (lg_done[i]) nd++;
         na += $countones(lg_ack[i]);
         if ((lg_ack[i] & ~lg_g[i]) != '0) bad++;
      end
      vec++;
      if (nd != npk || na != npay || bad != 0) begin
         err++;
         $display("FAIL rand%0d_totals: got done=%0d ack=%0d stray=%0d required %0d/%0d/0",
                  round, nd, na, bad, npk, npay);
      end
   endtask

   initial begin
      rst = 1'b0; pv = '0; cred = 1'b0; auto_mode = 0;
      cred_pct = 100; val_pct = 100; mptr = N - 1;
      clear_src();
      for (int k = 0; k < N; k++)
         for (int p = 0; p < 4; p++) new_pkt(k, p, 0);
      @(negedge clk);
      test_reset();
      test_single();
      test_round_robin();
      test_header_stall();
      test_size_zero();
      test_payload_gap();
      test_reset_midpacket();
      for (int r = 0; r < 3; r++) test_random(r);
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule
